shidianno_seq_ctrl: RTL
=======================

Name: shidianno_seq_ctrl

Overview:
- Sequencer for the ShiDianNao-style 3x3 output-stationary PE array and its shared scratch buffer.
- Computes one 3x3 convolution layer over a square input map.
- Per 3x3 output tile it:
  - fills the array from the buffer;
  - broadcasts the nine kernel weights in snake order;
  - between weights, streams in the new edge column or row and shifts the array.
- Sits between the layer-level host and the buffer/PE array. Owns every buffer read address, every read_control value and every PE control strobe.

Parameters:
- ADDR_BITS, 8, buffer address width.
- DIM_BITS, 4, width of the input-map dimension field.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that launches a layer; ignored while busy=1.
- cfg_in_dim  in  DIM_BITS  input map width/height N; sampled when start is accepted.
- cfg_in_base  in  ADDR_BITS  buffer address of input element [0][0] (row-major, stride N).
- cfg_k_base  in  ADDR_BITS  buffer address of kernel weight [0][0] (row-major, stride 3).
- buf_rd  out  1  buffer read issued this cycle.
- buf_addr  out  ADDR_BITS  buffer read address.
- buf_read_control  out  2  00 = column edge, 01 = input row/fill, 10 = kernel.
- pe_load  out  1  returned buffer data is written to the PE/edge register selected by pe_row_sel/pe_col_sel.
- pe_row_sel, pe_col_sel  out  2 each  target PE index, range 0..2.
- pe_shift  out  2  one-cycle shift pulse: 00 none, 01 toward col0 (new column enters at col2), 10 toward col2 (new column enters at col0), 11 toward row0 (new row enters at row2).
- pe_enable  out  1  MAC strobe; asserted in the cycle the kernel weight is valid.
- out_valid  out  1  tile results are ready in fixed_out.
- out_row, out_col  out  DIM_BITS each  tile origin (oy, ox), valid with out_valid.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of the layer.
- err  out  1  one-cycle pulse, coincident with done, for an illegal configuration.

Behaviour:
- Reset (async, reset_n=0): FSM goes to IDLE. All outputs are 0, all counters are 0.
- Reset mid-layer: the layer is abandoned; no done pulse is generated.
- Buffer read latency is 1 cycle. pe_load, with the sel values of read i, is asserted in the cycle after read i.
- Legality: O = N-2. The configuration is legal only if N ≥ 5 and O mod 3 = 0.
  - If illegal: next cycle goes to DONE with err=1. No buf_rd is issued.
- Tiles are processed in row-major order; oy and ox step by 3. Number of tiles = (O/3)^2.
- States, with cycles per visit:
  - IDLE: waits for start.
  - FILL (9): reads addr = in_base + (oy+r)*N + (ox+c), r-major; control 01.
  - FILL_W (1): final pe_load.
  - KRD (1): reads k_base + ky*3 + kx; control 10.
  - MAC (1): pe_enable=1.
  - EDGE (3): three edge reads.
  - EDGE_W (1): final pe_load.
  - SHIFT (1): pe_shift pulse.
  - OUT (1): out_valid=1.
  - DONE (1): done=1.
- Kernel order is snake: (0,0)(0,1)(0,2)(1,2)(1,1)(1,0)(2,0)(2,1)(2,2).
- After each MAC except the ninth, the FSM goes to EDGE. The edge is chosen by the next step (ky, kx are the current step):
  - kx+1: column c=2, addr in[oy+r+ky][ox+kx+3], control 00, shift 01.
  - kx-1: column c=0, addr in[oy+r+ky][ox+kx-1], control 00, shift 10.
  - ky+1: row r=2, addr in[oy+ky+3][ox+c+kx], control 01, shift 11.
  - Edge elements are issued with index 0, 1, 2.
- After the ninth MAC the FSM goes to OUT.
- After OUT: next tile goes to FILL; the last tile goes to DONE.
- DONE returns to IDLE.
- Per-tile latency is exactly 69 cycles: 9 + 1 + 18 + 40 + 1.
- Address arithmetic is unsigned and wraps modulo 2^ADDR_BITS.
- Only one of buf_rd, pe_enable, pe_shift, out_valid may be a new action in a given cycle. pe_load may coincide with buf_rd.
- start during busy is ignored. The cfg inputs are held internally for the whole layer.

Decomposition:
- Package shidianno_pkg holds:
  - read_control codes (RC_COL, RC_ROW, RC_KER);
  - pe_shift codes;
  - the FSM state enum;
  - ARR_DIM=3 and K_DIM=3 constants.
- Sub-module shidianno_addr_gen: combinational address computation from (oy, ox, ky, kx, edge index, mode).

Test Plan:
1. N=5, in_base=0, k_base=100, start at cycle 0 → FILL addrs 0,1,2,5,6,7,10,11,12 on cycles 1–9; KRD addr 100 at cycle 11; pe_enable at cycle 12.
2. Same run, first edge → addrs 3,8,13, control 00, then pe_shift=01. The edge after step (0,2) → addrs 17,18,19, control 01, pe_shift=11.
3. Same run → out_valid with (0,0) at cycle 69; done at cycle 70; busy falls after done; exactly 9 kernel reads, addrs 100..108 in snake order.
4. N=8 → out_valid at origins (0,0), (0,3), (3,0), (3,3) on cycles 69, 138, 207, 276; done at cycle 277.
5. N=6 (O=4) → done and err at cycle 1; no buf_rd; busy stays 0 after the pulse.
6. reset_n low at cycle 30 of the case-1 run → all outputs 0 immediately; no done; a new start after release reproduces case 1 timing.

Source files
------------

// File: rtl/shidianno_pkg.sv
// Shared codes, FSM state encoding and helpers for the ShiDianNao-style
// 3x3 tile sequencer.
package shidianno_pkg;

  localparam int unsigned ARR_DIM = 3;
  localparam int unsigned K_DIM   = 3;

  localparam logic [1:0] RC_COL = 2'b00;
  localparam logic [1:0] RC_ROW = 2'b01;
  localparam logic [1:0] RC_KER = 2'b10;

  localparam logic [1:0] SH_NONE    = 2'b00;
  localparam logic [1:0] SH_TO_COL0 = 2'b01;
  localparam logic [1:0] SH_TO_COL2 = 2'b10;
  localparam logic [1:0] SH_TO_ROW0 = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_FILL_W, S_KRD, S_MAC,
    S_EDGE, S_EDGE_W, S_SHIFT, S_OUT, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    AM_FILL, AM_KER, AM_COL_R, AM_COL_L, AM_ROW
  } addr_mode_t;

  function automatic logic dim_legal(input int unsigned n);
    return (n >= 5) && (((n - 2) % 3) == 0);
  endfunction

  // Snake order: even kernel rows walk right, odd rows walk left, row end steps down.
  function automatic addr_mode_t edge_mode(input logic [1:0] ky, input logic [1:0] kx);
    if (!ky[0]) return (kx == 2'(K_DIM - 1)) ? AM_ROW : AM_COL_R;
    return (kx == 2'd0) ? AM_ROW : AM_COL_L;
  endfunction

  function automatic logic [1:0] shift_code(input addr_mode_t m);
    case (m)
      AM_COL_R: return SH_TO_COL0;
      AM_COL_L: return SH_TO_COL2;
      AM_ROW:   return SH_TO_ROW0;
      default:  return SH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/shidianno_addr_gen.sv
// Combinational buffer address, read_control and PE target selection for
// fill, kernel and edge reads.
module shidianno_addr_gen
  import shidianno_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DIM_BITS  = 4
) (
  input  addr_mode_t           mode,
  input  logic [ADDR_BITS-1:0] in_base,
  input  logic [ADDR_BITS-1:0] k_base,
  input  logic [DIM_BITS-1:0]  dim,
  input  logic [DIM_BITS-1:0]  oy,
  input  logic [DIM_BITS-1:0]  ox,
  input  logic [1:0]           ky,
  input  logic [1:0]           kx,
  input  logic [1:0]           fill_r,
  input  logic [1:0]           fill_c,
  input  logic [1:0]           idx,
  output logic [ADDR_BITS-1:0] addr,
  output logic [1:0]           rd_ctl,
  output logic [1:0]           row_sel,
  output logic [1:0]           col_sel
);

  logic [ADDR_BITS-1:0] dr, dc, row, col, in_addr, k_addr;

  always_comb begin
    dr      = '0;
    dc      = '0;
    rd_ctl  = RC_ROW;
    row_sel = '0;
    col_sel = '0;
    case (mode)
      AM_FILL: begin
        dr      = ADDR_BITS'(fill_r);
        dc      = ADDR_BITS'(fill_c);
        row_sel = fill_r;
        col_sel = fill_c;
      end
      AM_COL_R: begin
        dr      = ADDR_BITS'(ky) + ADDR_BITS'(idx);
        dc      = ADDR_BITS'(kx) + ADDR_BITS'(K_DIM);
        rd_ctl  = RC_COL;
        row_sel = idx;
        col_sel = 2'(ARR_DIM - 1);
      end
      AM_COL_L: begin
        dr      = ADDR_BITS'(ky) + ADDR_BITS'(idx);
        dc      = ADDR_BITS'(kx) - ADDR_BITS'(1);
        rd_ctl  = RC_COL;
        row_sel = idx;
      end
      AM_ROW: begin
        dr      = ADDR_BITS'(ky) + ADDR_BITS'(K_DIM);
        dc      = ADDR_BITS'(kx) + ADDR_BITS'(idx);
        row_sel = 2'(ARR_DIM - 1);
        col_sel = idx;
      end
      AM_KER: rd_ctl = RC_KER;
      default: ;
    endcase
  end

  assign row     = ADDR_BITS'(oy) + dr;
  assign col     = ADDR_BITS'(ox) + dc;
  assign in_addr = in_base + row * ADDR_BITS'(dim) + col;
  assign k_addr  = k_base + ADDR_BITS'(ky) * ADDR_BITS'(K_DIM) + ADDR_BITS'(kx);
  assign addr    = (mode == AM_KER) ? k_addr : in_addr;

endmodule

// File: rtl/shidianno_seq_ctrl.sv
// Layer sequencer: walks 3x3 output tiles, fills the PE array, then
// alternates kernel broadcast / edge reload / shift in snake order.
module shidianno_seq_ctrl
  import shidianno_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DIM_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DIM_BITS-1:0]  cfg_in_dim,
  input  logic [ADDR_BITS-1:0] cfg_in_base,
  input  logic [ADDR_BITS-1:0] cfg_k_base,
  output logic                 buf_rd,
  output logic [ADDR_BITS-1:0] buf_addr,
  output logic [1:0]           buf_read_control,
  output logic                 pe_load,
  output logic [1:0]           pe_row_sel,
  output logic [1:0]           pe_col_sel,
  output logic [1:0]           pe_shift,
  output logic                 pe_enable,
  output logic                 out_valid,
  output logic [DIM_BITS-1:0]  out_row,
  output logic [DIM_BITS-1:0]  out_col,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t               state, state_nx;
  logic [DIM_BITS-1:0]  dim, o_last, oy, ox;
  logic [ADDR_BITS-1:0] in_base, k_base, addr;
  logic [1:0]           ky, kx, fill_r, fill_c, idx;
  logic [1:0]           rd_ctl, row_sel, col_sel;
  logic                 err_q, rd, fill_last, step_last, tile_last, cfg_ok;
  addr_mode_t           mode, edge_m;

  assign cfg_ok    = dim_legal(32'(cfg_in_dim));
  assign edge_m    = edge_mode(ky, kx);
  assign fill_last = (fill_r == 2'(ARR_DIM - 1)) && (fill_c == 2'(ARR_DIM - 1));
  assign step_last = (ky == 2'(K_DIM - 1)) && (kx == 2'(K_DIM - 1));
  assign tile_last = (ox == o_last) && (oy == o_last);

  shidianno_addr_gen #(.ADDR_BITS(ADDR_BITS), .DIM_BITS(DIM_BITS)) u_addr_gen (
    .mode(mode), .in_base(in_base), .k_base(k_base), .dim(dim), .oy(oy), .ox(ox),
    .ky(ky), .kx(kx), .fill_r(fill_r), .fill_c(fill_c), .idx(idx),
    .addr(addr), .rd_ctl(rd_ctl), .row_sel(row_sel), .col_sel(col_sel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mode     = AM_FILL;
    rd       = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = cfg_ok ? S_FILL : S_DONE;
      S_FILL: begin
        rd = 1'b1;
        if (fill_last) state_nx = S_FILL_W;
      end
      S_FILL_W: state_nx = S_KRD;
      S_KRD: begin
        rd       = 1'b1;
        mode     = AM_KER;
        state_nx = S_MAC;
      end
      S_MAC:    state_nx = step_last ? S_OUT : S_EDGE;
      S_EDGE: begin
        rd   = 1'b1;
        mode = edge_m;
        if (idx == 2'(ARR_DIM - 1)) state_nx = S_EDGE_W;
      end
      S_EDGE_W: state_nx = S_SHIFT;
      S_SHIFT:  state_nx = S_KRD;
      S_OUT:    state_nx = tile_last ? S_DONE : S_FILL;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dim     <= '0;
      o_last  <= '0;
      in_base <= '0;
      k_base  <= '0;
      oy      <= '0;
      ox      <= '0;
      ky      <= '0;
      kx      <= '0;
      fill_r  <= '0;
      fill_c  <= '0;
      idx     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          dim     <= cfg_in_dim;
          o_last  <= cfg_in_dim - DIM_BITS'(5);
          in_base <= cfg_in_base;
          k_base  <= cfg_k_base;
          oy      <= '0;
          ox      <= '0;
          ky      <= '0;
          kx      <= '0;
          fill_r  <= '0;
          fill_c  <= '0;
          idx     <= '0;
          err_q   <= !cfg_ok;
        end
        S_FILL: begin
          if (fill_c == 2'(ARR_DIM - 1)) begin
            fill_c <= '0;
            fill_r <= fill_last ? '0 : fill_r + 2'd1;
          end else begin
            fill_c <= fill_c + 2'd1;
          end
        end
        S_EDGE:  idx <= (idx == 2'(ARR_DIM - 1)) ? '0 : idx + 2'd1;
        S_SHIFT: begin
          case (edge_m)
            AM_COL_R: kx <= kx + 2'd1;
            AM_COL_L: kx <= kx - 2'd1;
            default:  ky <= ky + 2'd1;
          endcase
        end
        S_OUT: begin
          ky <= '0;
          kx <= '0;
          if (ox == o_last) begin
            ox <= '0;
            oy <= tile_last ? '0 : oy + DIM_BITS'(ARR_DIM);
          end else begin
            ox <= ox + DIM_BITS'(ARR_DIM);
          end
        end
        S_DONE:  err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Buffer data returns one cycle after the read, so the PE write strobe lags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_load    <= 1'b0;
      pe_row_sel <= '0;
      pe_col_sel <= '0;
    end else begin
      pe_load    <= rd && (mode != AM_KER);
      pe_row_sel <= rd ? row_sel : '0;
      pe_col_sel <= rd ? col_sel : '0;
    end
  end

  assign buf_rd           = rd;
  assign buf_addr         = rd ? addr : '0;
  assign buf_read_control = rd ? rd_ctl : RC_COL;
  assign pe_shift         = (state == S_SHIFT) ? shift_code(edge_m) : SH_NONE;
  assign pe_enable        = (state == S_MAC);
  assign out_valid        = (state == S_OUT);
  assign out_row          = out_valid ? oy : '0;
  assign out_col          = out_valid ? ox : '0;
  assign busy             = (state != S_IDLE);
  assign done             = (state == S_DONE);
  assign err              = done && err_q;

endmodule
